// File: rtl/clk_en_gen.sv
// Fractional-N clock-enable generator with a lock-qualified reset sequencer.
// Latency: lock sync SYNC_STAGES edges; release SYNC_STAGES+LOCK_CYCLES+2 edges; ce one edge after carry.
// Backpressure: one pending increment write; cfg_ready low until the target channel's period boundary.
//
// Ports:
//   clkin      PLL output clock, the only clock of this block
//   rst        asynchronous active-high reset
//   pll_locked raw PLL lock, asynchronous to clkin
//   cfg_valid/cfg_ready/cfg_ch/cfg_inc  increment write port (valid/ready)
//   ce         per-channel single-cycle enable pulses
//   sync_rst   downstream reset, high whenever the sequencer is not in RUN
//   ready      high only while the sequencer is in RUN
module clk_en_gen #(
    parameter int               NUM_CH      = 2,
    parameter int               ACC_W       = 24,
    parameter logic [ACC_W-1:0] INC_DEFAULT = 24'd5592405,
    parameter int               LOCK_CYCLES = 1024,
    parameter int               SYNC_STAGES = 2,
    localparam int              CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clkin,
    input  logic              rst,
    input  logic              pll_locked,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [ACC_W-1:0]  cfg_inc,
    output logic [NUM_CH-1:0] ce,
    output logic              sync_rst,
    output logic              ready
);

    localparam int CNT_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;

    typedef enum logic [1:0] {
        HOLD = 2'd0,
        WAIT = 2'd1,
        RUN  = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Lock synchroniser: the only place the raw PLL lock is sampled.
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] lock_sync;
    logic                   lock_s;

    always_ff @(posedge clkin or posedge rst) begin
        if (rst) begin
            lock_sync <= '0;
        end else begin
            lock_sync <= {lock_sync[SYNC_STAGES-2:0], pll_locked};
        end
    end

    assign lock_s = lock_sync[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // Reset sequencer. Lock must be seen high for LOCK_CYCLES consecutive
    // cycles in WAIT before release; any low sample restarts the count.
    // Loss of lock in RUN drops straight back to HOLD (no hysteresis).
    // ------------------------------------------------------------------
    state_t           state;
    logic [CNT_W-1:0] stable_cnt;
    logic             run;

    always_ff @(posedge clkin or posedge rst) begin
        if (rst) begin
            state      <= HOLD;
            stable_cnt <= '0;
            sync_rst   <= 1'b1;
            ready      <= 1'b0;
        end else begin
            case (state)
                HOLD: begin
                    stable_cnt <= '0;
                    if (lock_s) begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (!lock_s) begin
                        state      <= HOLD;
                        stable_cnt <= '0;
                    end else if (stable_cnt == CNT_W'(LOCK_CYCLES - 1)) begin
                        state      <= RUN;
                        stable_cnt <= '0;
                    end else begin
                        stable_cnt <= stable_cnt + CNT_W'(1);
                    end
                end
                RUN: begin
                    stable_cnt <= '0;
                    if (!lock_s) begin
                        state <= HOLD;
                    end
                end
                default: begin
                    state      <= HOLD;
                    stable_cnt <= '0;
                end
            endcase
            // Outputs follow the state register by one edge.
            sync_rst <= (state != RUN);
            ready    <= (state == RUN);
        end
    end

    assign run = (state == RUN);

    // ------------------------------------------------------------------
    // Phase accumulators. The carry out of the ACC_W-bit add is the enable.
    // ------------------------------------------------------------------
    logic [ACC_W-1:0]  acc [NUM_CH];
    logic [ACC_W-1:0]  inc [NUM_CH];
    logic [ACC_W-1:0]  sum [NUM_CH];
    logic [NUM_CH-1:0] carry;

    always_comb begin
        carry = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            sum[i] = '0;
            {carry[i], sum[i]} = {1'b0, acc[i]} + {1'b0, inc[i]};
        end
    end

    always_ff @(posedge clkin or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                acc[i] <= '0;
            end
            ce <= '0;
        end else if (run) begin
            for (int i = 0; i < NUM_CH; i++) begin
                acc[i] <= sum[i];
            end
            ce <= carry;
        end else begin
            // Outside RUN every channel restarts from phase 0.
            for (int i = 0; i < NUM_CH; i++) begin
                acc[i] <= '0;
            end
            ce <= '0;
        end
    end

    // ------------------------------------------------------------------
    // Increment reprogramming through a single pending slot.
    // In RUN the slot is only committed on the target channel's carry, so
    // the period in progress always completes with its old increment.
    // A stopped channel (inc 0), a write outside RUN, or a write to a
    // non-existent channel commits on the first cycle the slot is full.
    // ------------------------------------------------------------------
    logic             pend_vld;
    logic [CH_W-1:0]  pend_ch;
    logic [ACC_W-1:0] pend_inc;
    logic             ch_hit;
    logic             tgt_idle;
    logic             tgt_carry;
    logic             commit;

    assign cfg_ready = ~pend_vld;

    always_comb begin
        ch_hit    = 1'b0;
        tgt_idle  = 1'b0;
        tgt_carry = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (pend_ch == CH_W'(i)) begin
                ch_hit    = 1'b1;
                tgt_idle  = (inc[i] == '0);
                tgt_carry = carry[i];
            end
        end
        commit = pend_vld && (!run || !ch_hit || tgt_idle || tgt_carry);
    end

    always_ff @(posedge clkin or posedge rst) begin
        if (rst) begin
            pend_vld <= 1'b0;
            pend_ch  <= '0;
            pend_inc <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                inc[i] <= INC_DEFAULT;
            end
        end else begin
            if (commit) begin
                pend_vld <= 1'b0;
                // An out-of-range channel matches no entry and is dropped.
                for (int i = 0; i < NUM_CH; i++) begin
                    if (pend_ch == CH_W'(i)) begin
                        inc[i] <= pend_inc;
                    end
                end
            end else if (cfg_valid && !pend_vld) begin
                pend_vld <= 1'b1;
                pend_ch  <= cfg_ch;
                pend_inc <= cfg_inc;
            end
        end
    end

endmodule
